// File: rtl/hilo_ctrl.sv
// hilo_ctrl: execute-stage owner of HI/LO; decodes hilo_op and sequences the external multiplier/divider.
//   clk, rst                : clock, synchronous active-high reset
//   flush                   : kills any in-flight op, pulses div_annul if the divider is still busy
//   valid_i, hilo_op        : {mfhi,mflo,mthi,mtlo,mult,multu,div,divu,mul}, at most one bit set
//   rs_data, rt_data        : operands
//   stallreq, res_o         : stall toward pipeline control, GPR result for mfhi/mflo/mul
//   mul_a/b/signed, mul_p   : fixed-latency multiplier interface
//   div_start/a/b/signed/annul, div_ready/q/r : handshaked divider interface
module hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_i,
  input  logic [8:0]  hilo_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stallreq,
  output logic [31:0] res_o,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_p,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_signed,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);
  localparam logic [1:0] IDLE = 2'd0, MUL_WAIT = 2'd1, DIV_WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [31:0] hi, lo, opnd_a, opnd_b, mul_res;
  logic        sgn, kind_mul, acc, op_mul, op_div;
  assign op_mul = hilo_op[4] | hilo_op[3] | hilo_op[0];
  assign op_div = hilo_op[2] | hilo_op[1];
  assign acc = state == IDLE && valid_i && !flush;
  assign mul_a = opnd_a;
  assign mul_b = opnd_b;
  assign div_a = opnd_a;
  assign div_b = opnd_b;
  assign mul_signed = sgn;
  assign div_signed = sgn;
  // DONE drops the stall for one cycle so the held instruction retires without being re-accepted
  always_comb begin
    stallreq = !rst && !flush && (state == MUL_WAIT || state == DIV_WAIT || (acc && (op_mul || op_div)));
    res_o = rst ? '0 :
            (acc && hilo_op[8]) ? hi :
            (acc && hilo_op[7]) ? lo :
            (state == DONE && kind_mul) ? mul_res : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
      mul_res <= '0;
      sgn <= 1'b0;
      kind_mul <= 1'b0;
      div_start <= 1'b0;
      div_annul <= 1'b0;
    end else begin
      div_start <= 1'b0;
      div_annul <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt <= '0;
        div_annul <= state == DIV_WAIT && !div_ready;
      end else begin
        case (state)
          IDLE: if (valid_i) begin
            if (hilo_op[6]) hi <= rs_data;
            if (hilo_op[5]) lo <= rs_data;
            if (op_mul || op_div) begin
              opnd_a <= rs_data;
              opnd_b <= rt_data;
              sgn <= hilo_op[4] | hilo_op[2] | hilo_op[0];
              kind_mul <= hilo_op[0];
            end
            if (op_mul) begin
              cnt <= 3'd1;
              state <= MUL_WAIT;
            end
            if (op_div) begin
              div_start <= 1'b1;
              state <= DIV_WAIT;
            end
          end
          MUL_WAIT: if (cnt == 3'(MUL_LAT)) begin
            if (kind_mul) mul_res <= mul_p[31:0];
            else {hi, lo} <= mul_p;
            cnt <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
          DIV_WAIT: if (div_ready) begin
            hi <= div_r;
            lo <= div_q;
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed table plus randomized checks of hilo_ctrl against a spec-level model.
module tb_hilo_ctrl;
  localparam int MUL_LAT = 2;
  localparam logic [8:0] MFHI = 9'h100, MFLO = 9'h080, MTHI = 9'h040, MTLO = 9'h020,
                         MULT = 9'h010, MULTU = 9'h008, DIV = 9'h004, DIVU = 9'h002, MUL = 9'h001;
  logic        clk = 0, rst = 1, flush = 0, valid_i = 0, div_ready = 0;
  logic [8:0]  hilo_op = 0;
  logic [31:0] rs_data = 0, rt_data = 0, div_q = 0, div_r = 0;
  logic        stallreq, mul_signed, div_start, div_signed, div_annul;
  logic [31:0] res_o, mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_p, prod;
  logic [63:0] pipe [0:6];
  int checks = 0, errors = 0;
  logic [31:0] mhi = 0, mlo = 0;

  hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .hilo_op(hilo_op),
    .rs_data(rs_data), .rt_data(rt_data), .stallreq(stallreq), .res_o(res_o),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_p(mul_p),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_signed(div_signed),
    .div_annul(div_annul), .div_ready(div_ready), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  // pipelined multiplier: product of the operands seen MUL_LAT-1 cycles ago
  assign prod = {{32{mul_signed & mul_a[31]}}, mul_a} * {{32{mul_signed & mul_b[31]}}, mul_b};
  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = (MUL_LAT == 1) ? prod : pipe[MUL_LAT-2];

  always @(negedge clk) if (valid_i && !rst) assert ($onehot0(hilo_op)) else $error("illegal hilo_op %h", hilo_op);

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input bit h, input logic [31:0] exp);
    valid_i = 1;
    hilo_op = h ? MFHI : MFLO;
    @(negedge clk);
    chk(h ? "res_mfhi" : "res_mflo", 64'(res_o), 64'(exp));
    chk("rd_stall", 64'(stallreq), 64'(0));
    tick();
    valid_i = 0;
    hilo_op = 0;
  endtask

  task automatic wr(input bit h, input logic [31:0] v);
    valid_i = 1;
    hilo_op = h ? MTHI : MTLO;
    rs_data = v;
    @(negedge clk);
    chk("wr_stall", 64'(stallreq), 64'(0));
    tick();
    valid_i = 0;
    hilo_op = 0;
  endtask

  // run one multi-cycle op, flushing in cycle fl (0 = acceptance cycle, -1 = never); divider answers in cycle n
  task automatic run_multi(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int n, input int fl, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic [31:0] eres, input int estall, input bit eannul);
    int cyc, stalls, starts, cap;
    bit done, is_div;
    logic [31:0] r;
    is_div = op == DIV || op == DIVU;
    cap = is_div ? n : MUL_LAT;
    valid_i = 1;
    hilo_op = op;
    rs_data = a;
    rt_data = b;
    cyc = 0;
    stalls = 0;
    starts = 0;
    done = 0;
    r = 0;
    while (!done && cyc < 100) begin
      flush = cyc == fl;
      div_ready = is_div && cyc == n;
      if (div_ready) begin
        if (div_signed) begin
          div_q = 32'(int'(div_a) / int'(div_b));
          div_r = 32'(int'(div_a) % int'(div_b));
        end else begin
          div_q = div_a / div_b;
          div_r = div_a % div_b;
        end
      end
      @(negedge clk);
      if (div_start) begin
        starts++;
        chk("div_start_cycle", 64'(cyc), 64'(1));
      end
      if (cyc == 1 && stallreq) begin
        if (is_div) begin
          chk("div_a", 64'(div_a), 64'(a));
          chk("div_b", 64'(div_b), 64'(b));
          chk("div_signed", 64'(div_signed), 64'(op == DIV));
        end else begin
          chk("mul_a", 64'(mul_a), 64'(a));
          chk("mul_b", 64'(mul_b), 64'(b));
          chk("mul_signed", 64'(mul_signed), 64'(op == MULT || op == MUL));
        end
      end
      if (stallreq) stalls++;
      else begin
        done = 1;
        r = res_o;
      end
      tick();
      cyc++;
    end
    if (!done) chk("release_timeout", 64'(cyc), 64'(estall));
    chk("stall_cycles", 64'(stalls), 64'(estall));
    chk("div_start_pulses", 64'(starts), 64'(is_div && fl != 0));
    if (fl < 0 || fl > cap) chk("done_res", 64'(r), 64'(eres));
    valid_i = 0;
    flush = 0;
    div_ready = 0;
    hilo_op = 0;
    @(negedge clk);
    chk("div_annul", 64'(div_annul), 64'(eannul));
    chk("idle_stall", 64'(stallreq), 64'(0));
    tick();
    @(negedge clk);
    chk("div_annul_once", 64'(div_annul), 64'(0));
    tick();
    rd(1, ehi);
    rd(0, elo);
  endtask

  typedef struct {
    logic [8:0]  op;
    logic [31:0] a, b;
    int          n, fl;
    logic [31:0] ehi, elo, eres;
    int          estall;
    bit          eannul;
  } vec_t;
  vec_t tv [10];

  initial begin
    tv[0] = '{MULT,  32'hFFFF_FFFE, 32'd3, 1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 3, 0};
    tv[1] = '{MULTU, 32'hFFFF_FFFE, 32'd3, 1, -1, 32'h0000_0002, 32'hFFFF_FFFA, 32'd0, 3, 0};
    tv[2] = '{MUL,   32'd7, 32'd6, 1, -1, 32'h0000_0002, 32'hFFFF_FFFA, 32'd42, 3, 0};
    tv[3] = '{DIVU,  32'd100, 32'd7, 10, -1, 32'd2, 32'd14, 32'd0, 11, 0};
    tv[4] = '{DIV,   32'hFFFF_FFF9, 32'd2, 3, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 4, 0};
    tv[5] = '{DIVU,  32'd55, 32'd5, 10, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 5, 1};
    tv[6] = '{DIVU,  32'd9, 32'd2, 4, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 4, 0};
    tv[7] = '{MULT,  32'd5, 32'd5, 1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 2, 0};
    tv[8] = '{MULT,  32'd1, 32'd1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 0, 0};
    tv[9] = '{MUL,   32'd3, 32'd4, 1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd12, 3, 0};
    valid_i = 1;
    hilo_op = MFHI;
    @(negedge clk);
    chk("rst_stall", 64'(stallreq), 64'(0));
    chk("rst_res", 64'(res_o), 64'(0));
    tick();
    tick();
    rst = 0;
    valid_i = 0;
    hilo_op = 0;
    @(negedge clk);
    chk("rst_mul_a", 64'(mul_a), 64'(0));
    chk("rst_div_b", 64'(div_b), 64'(0));
    chk("rst_div_start", 64'(div_start), 64'(0));
    chk("rst_div_annul", 64'(div_annul), 64'(0));
    tick();
    wr(1, 32'h1234_5678);
    rd(0, 32'h0);
    rd(1, 32'h1234_5678);
    for (int i = 0; i < 10; i++)
      run_multi(tv[i].op, tv[i].a, tv[i].b, tv[i].n, tv[i].fl, tv[i].ehi, tv[i].elo, tv[i].eres, tv[i].estall, tv[i].eannul);
    valid_i = 1;
    hilo_op = MULT;
    rs_data = 5;
    rt_data = 6;
    @(negedge clk);
    chk("mid_rst_accept_stall", 64'(stallreq), 64'(1));
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_rst_stall", 64'(stallreq), 64'(0));
    chk("mid_rst_res", 64'(res_o), 64'(0));
    tick();
    rst = 0;
    valid_i = 0;
    hilo_op = 0;
    @(negedge clk);
    chk("mid_rst_mul_a", 64'(mul_a), 64'(0));
    chk("mid_rst_mul_b", 64'(mul_b), 64'(0));
    chk("mid_rst_sign", 64'(mul_signed), 64'(0));
    chk("mid_rst_div_start", 64'(div_start), 64'(0));
    chk("mid_rst_annul", 64'(div_annul), 64'(0));
    chk("mid_rst_idle_stall", 64'(stallreq), 64'(0));
    tick();
    rd(1, 32'h0);
    rd(0, 32'h0);
    mhi = 0;
    mlo = 0;
    for (int it = 0; it < 60; it++) begin
      logic [8:0] op;
      logic [31:0] a, b, q, rm, eres;
      logic [63:0] p;
      int n, fl, cap, sa, sb;
      bit is_div, flushed;
      op = 9'h1 << $urandom_range(0, 8);
      a = $urandom;
      b = $urandom;
      if (op == MTHI) begin
        wr(1, a);
        mhi = a;
      end else if (op == MTLO) begin
        wr(0, a);
        mlo = a;
      end else if (op == MFHI) rd(1, mhi);
      else if (op == MFLO) rd(0, mlo);
      else begin
        is_div = op == DIV || op == DIVU;
        if (is_div && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) b = 32'd3;
        n = $urandom_range(1, 6);
        cap = is_div ? n : MUL_LAT;
        fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cap + 1)) : -1;
        flushed = fl >= 0 && fl <= cap;
        sa = int'(a);
        sb = int'(b);
        eres = 0;
        if (op == MULT || op == MUL) p = 64'(longint'(sa) * longint'(sb));
        else p = {32'b0, a} * {32'b0, b};
        if (op == DIV) begin
          q = 32'(sa / sb);
          rm = 32'(sa % sb);
        end else begin
          q = a / b;
          rm = a % b;
        end
        if (!flushed) begin
          if (op == MUL) eres = p[31:0];
          else if (is_div) begin
            mhi = rm;
            mlo = q;
          end else begin
            mhi = p[63:32];
            mlo = p[31:0];
          end
        end
        run_multi(op, a, b, n, fl, mhi, mlo, eres, flushed ? fl : cap + 1,
                  is_div && flushed && fl >= 1 && fl < n);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
